// File: rtl/axis_128b_to_16b_if.sv
// AXI-Stream bundle shared by the wide (128B) and narrow (16B) sides of the TX down-converter.
`timescale 1ns/1ps
interface axis_128b_to_16b_if #(
    parameter int DATA_W = 128,
    parameter int USER_W = 8,
    parameter int TID_W  = 3
) ();
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic [TID_W-1:0]  tid;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, tuser, tid, tvalid, tlast, input tready);
    modport slave  (input tdata, tuser, tid, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_128b_to_16b.sv
// TX width down-converter: one 128-byte AXIS beat becomes up to eight 16-byte flits in wire byte order.
// Optional sticky protocol checks on the input side are enabled with AXIS_DN_ERR_CHK_EN.
`timescale 1ns/1ps
module axis_128b_to_16b #(
    parameter int TID_W     = 3,
    parameter bit HOLD_ZERO = 1'b0
) (
    input  logic clk,
    input  logic rst,
    axis_128b_to_16b_if.slave  s_axis,
    axis_128b_to_16b_if.master m_axis
`ifdef AXIS_DN_ERR_CHK_EN
    ,
    output logic [2:0] err_o
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nxt;
    logic [1023:0]    hold_data;
    logic             hold_sop;
    logic             hold_eop;
    logic [TID_W-1:0] hold_tid;
    logic [2:0]       flit_idx;
    logic [2:0]       last_idx;
    logic [3:0]       last_bc;
    logic [7:0]       nbytes_in;
    logic [7:0]       nbytes_m1;
    logic             s_hs;
    logic             m_hs;
    logic             final_flit;
    logic [127:0]     lane;
    logic [2:0]       unused_bits;

    assign unused_bits = {s_axis.tuser[9:7]} ^ {nbytes_m1[7], 2'b00};

    // Byte count of the incoming beat; empty only matters when the beat closes a packet.
    assign nbytes_in  = s_axis.tlast ? (8'd128 - {1'b0, s_axis.tuser[6:0]}) : 8'd128;
    assign nbytes_m1  = nbytes_in - 8'd1;
    assign final_flit = (flit_idx == last_idx);
    assign s_hs       = s_axis.tvalid && s_axis.tready;
    assign m_hs       = m_axis.tvalid && m_axis.tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        m_axis.tvalid = 1'b0;
        s_axis.tready = 1'b0;
        case (state)
            IDLE: begin
                s_axis.tready = !rst;
                if (s_axis.tvalid) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                m_axis.tvalid = 1'b1;
                // Accept the next beat alongside the final flit so the output has no bubble.
                s_axis.tready = !rst && m_axis.tready && final_flit;
                if (m_axis.tready && final_flit) begin
                    state_nxt = s_axis.tvalid ? SEND : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            hold_sop  <= 1'b0;
            hold_eop  <= 1'b0;
            hold_tid  <= '0;
            flit_idx  <= '0;
            last_idx  <= '0;
            last_bc   <= '0;
        end else if (s_hs) begin
            hold_data <= s_axis.tdata;
            hold_sop  <= s_axis.tuser[10];
            hold_eop  <= s_axis.tlast;
            hold_tid  <= s_axis.tid;
            flit_idx  <= '0;
            last_idx  <= nbytes_m1[6:4];
            last_bc   <= nbytes_m1[3:0];
        end else if (m_hs && !final_flit) begin
            flit_idx <= flit_idx + 3'd1;
        end
    end

    // Lanes are stored byte-reversed relative to the wire, so each flit flips its 16 bytes.
    always_comb begin
        lane          = '0;
        m_axis.tdata  = '0;
        m_axis.tuser  = '0;
        m_axis.tid    = '0;
        m_axis.tlast  = 1'b0;
        if (state == SEND) begin
            lane = hold_data[{flit_idx, 7'd0} +: 128];
            for (int j = 0; j < 16; j++) begin
                if (HOLD_ZERO && final_flit && (j > int'(last_bc))) begin
                    m_axis.tdata[j*8 +: 8] = 8'h00;
                end else begin
                    m_axis.tdata[j*8 +: 8] = lane[(15-j)*8 +: 8];
                end
            end
            m_axis.tuser[7]   = hold_sop && (flit_idx == 3'd0);
            m_axis.tuser[6:0] = final_flit ? {3'b000, last_bc} : 7'd15;
            m_axis.tid        = hold_tid;
            m_axis.tlast      = hold_eop && final_flit;
        end
    end

`ifdef AXIS_DN_ERR_CHK_EN
    logic pkt_open;

    // A packet stays open from a sop beat until a beat with tlast is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o    <= 3'b000;
            pkt_open <= 1'b0;
        end else if (s_hs) begin
            if (s_axis.tlast != s_axis.tuser[9]) begin
                err_o[0] <= 1'b1;
            end
            if (s_axis.tuser[10] && pkt_open) begin
                err_o[1] <= 1'b1;
            end
            if (!s_axis.tlast && (s_axis.tuser[6:0] != 7'd0)) begin
                err_o[2] <= 1'b1;
            end
            if (s_axis.tlast) begin
                pkt_open <= 1'b0;
            end else if (s_axis.tuser[10]) begin
                pkt_open <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_128b_to_16b.sv
// Scoreboard bench for axis_128b_to_16b: two instances (HOLD_ZERO 0 and 1) share identical stimulus.
`timescale 1ns/1ps
module tb_axis_128b_to_16b;

    localparam int TID_W = 3;

    typedef struct {
        logic [127:0]     data;
        logic [127:0]     data_hz;
        logic [7:0]       user;
        logic [TID_W-1:0] tid;
        logic             last;
    } flit_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_128b_to_16b_if #(.DATA_W(1024), .USER_W(11), .TID_W(TID_W)) s0 ();
    axis_128b_to_16b_if #(.DATA_W(1024), .USER_W(11), .TID_W(TID_W)) s1 ();
    axis_128b_to_16b_if #(.DATA_W(128),  .USER_W(8),  .TID_W(TID_W)) m0 ();
    axis_128b_to_16b_if #(.DATA_W(128),  .USER_W(8),  .TID_W(TID_W)) m1 ();

    assign s1.tdata  = s0.tdata;
    assign s1.tuser  = s0.tuser;
    assign s1.tid    = s0.tid;
    assign s1.tvalid = s0.tvalid;
    assign s1.tlast  = s0.tlast;
    assign m1.tready = m0.tready;

`ifdef AXIS_DN_ERR_CHK_EN
    logic [2:0] err0;
    logic [2:0] err1;
`endif

    axis_128b_to_16b #(.TID_W(TID_W), .HOLD_ZERO(1'b0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s0),
        .m_axis (m0)
`ifdef AXIS_DN_ERR_CHK_EN
        ,
        .err_o  (err0)
`endif
    );

    axis_128b_to_16b #(.TID_W(TID_W), .HOLD_ZERO(1'b1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s1),
        .m_axis (m1)
`ifdef AXIS_DN_ERR_CHK_EN
        ,
        .err_o  (err1)
`endif
    );

    flit_t exp_q[$];
    logic  rdy_log[$];
    int    checks = 0;
    int    fails = 0;
    int    cycle = 0;
    int    hs_count = 0;
    int    hs_first = 0;
    int    hs_last = 0;

    always @(posedge clk) cycle++;

    // Scoreboard consumer: every flit handshake pops and compares one expected flit.
    always @(negedge clk) begin
        flit_t e;
        if (m0.tvalid && m0.tready) begin
            if (hs_count == 0) hs_first = cycle;
            hs_last = cycle;
            hs_count++;
            rdy_log.push_back(s0.tready);
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_flit: got tdata=%h tuser=%h, required no flit", m0.tdata, m0.tuser);
            end else begin
                e = exp_q.pop_front();
                checks += 4;
                if (m0.tdata !== e.data) begin
                    fails++;
                    $display("[TB] FAIL flit_data: got %h, required %h", m0.tdata, e.data);
                end
                if (m0.tuser !== e.user) begin
                    fails++;
                    $display("[TB] FAIL flit_tuser: got %h, required %h", m0.tuser, e.user);
                end
                if (m0.tid !== e.tid || m0.tlast !== e.last) begin
                    fails++;
                    $display("[TB] FAIL flit_tid_tlast: got tid=%0d tlast=%b, required tid=%0d tlast=%b",
                             m0.tid, m0.tlast, e.tid, e.last);
                end
                if (m1.tdata !== e.data_hz || m1.tvalid !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL flit_data_hold_zero: got %h valid=%b, required %h valid=1",
                             m1.tdata, m1.tvalid, e.data_hz);
                end
            end
        end
    end

    function automatic logic [1023:0] rand_beat();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Builds the expected flits from the beat and pushes them, then waits for acceptance.
    task automatic drive_beat(input logic [1023:0] data, input logic sop, input logic eop_bit,
                              input logic tlast, input logic [6:0] empty, input logic [TID_W-1:0] tid);
        flit_t f;
        int    nb;
        int    nflits;
        int    bc;
        int    n;
        logic [127:0] lane;
        nb     = tlast ? 128 - int'(empty) : 128;
        nflits = (nb + 15) / 16;
        for (int i = 0; i < nflits; i++) begin
            lane = data[i*128 +: 128];
            bc   = (i == nflits - 1) ? ((nb - 1) % 16) : 15;
            for (int j = 0; j < 16; j++) begin
                f.data[j*8 +: 8]    = lane[(15-j)*8 +: 8];
                f.data_hz[j*8 +: 8] = (j > bc) ? 8'h00 : lane[(15-j)*8 +: 8];
            end
            f.user = {sop && (i == 0), 7'(bc)};
            f.tid  = tid;
            f.last = tlast && (i == nflits - 1);
            exp_q.push_back(f);
        end
        s0.tdata  = data;
        s0.tuser  = {sop, eop_bit, 2'b00, empty};
        s0.tid    = tid;
        s0.tlast  = tlast;
        s0.tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s0.tready && n < 300);
        if (!s0.tready) begin
            checks++;
            fails++;
            $display("[TB] FAIL beat_accept_timeout: got tready=0 after %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        s0.tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d flits outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        s0.tvalid = 1'b0;
        s0.tdata  = '0;
        s0.tuser  = '0;
        s0.tid    = '0;
        s0.tlast  = 1'b0;
        m0.tready = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks += 2;
        if ({m0.tvalid, m0.tdata, m0.tuser, m0.tid, m0.tlast} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got valid=%b user=%h tlast=%b, required all zero",
                     m0.tvalid, m0.tuser, m0.tlast);
        end
        if (s0.tready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_s_tready: got %b, required 0", s0.tready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (s0.tready !== 1'b1 || m0.tvalid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: got s_tready=%b m_tvalid=%b, required 1/0", s0.tready, m0.tvalid);
        end
    endtask

    task automatic test_full_beat();
        logic [1023:0] d;
        for (int k = 0; k < 128; k++) d[k*8 +: 8] = 8'(k);
        m0.tready = 1'b1;
        hs_count  = 0;
        drive_beat(d, 1'b1, 1'b1, 1'b1, 7'd0, 3'd5);
        checks++;
        if (m0.tvalid !== 1'b1 || m0.tuser !== 8'h8F) begin
            fails++;
            $display("[TB] FAIL first_flit_latency: got valid=%b tuser=%h, required 1/8f", m0.tvalid, m0.tuser);
        end
        wait_drain();
        checks++;
        if (hs_count != 8) begin
            fails++;
            $display("[TB] FAIL full_beat_count: got %0d flits, required 8", hs_count);
        end
    endtask

    task automatic test_two_flit();
        hs_count = 0;
        drive_beat(rand_beat(), 1'b1, 1'b1, 1'b1, 7'd100, 3'd2);
        wait_drain();
        checks++;
        if (hs_count != 2) begin
            fails++;
            $display("[TB] FAIL two_flit_count: got %0d flits, required 2", hs_count);
        end
    endtask

    task automatic test_non_eop();
        hs_count = 0;
        drive_beat(rand_beat(), 1'b1, 1'b0, 1'b0, 7'd5, 3'd1);
        wait_drain();
        checks++;
        if (hs_count != 8) begin
            fails++;
            $display("[TB] FAIL non_eop_count: got %0d flits, required 8", hs_count);
        end
    endtask

    task automatic test_back_to_back();
        int early;
        m0.tready = 1'b1;
        hs_count  = 0;
        rdy_log.delete();
        drive_beat(rand_beat(), 1'b1, 1'b0, 1'b0, 7'd0, 3'd3);
        drive_beat(rand_beat(), 1'b0, 1'b1, 1'b1, 7'd127, 3'd3);
        wait_drain();
        checks += 3;
        if (hs_count != 9 || (hs_last - hs_first) != 8) begin
            fails++;
            $display("[TB] FAIL b2b_no_bubble: got %0d flits over %0d cycles, required 9 over 9",
                     hs_count, hs_last - hs_first + 1);
        end
        early = 0;
        for (int i = 0; i < 7 && i < rdy_log.size(); i++) if (rdy_log[i]) early++;
        if (early != 0) begin
            fails++;
            $display("[TB] FAIL b2b_early_tready: got %0d early pulses, required 0", early);
        end
        if (rdy_log.size() < 8 || rdy_log[7] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_tready_pulse: got log size %0d, required tready=1 on flit 8", rdy_log.size());
        end
    endtask

    task automatic test_stall();
        logic [127:0]     pd;
        logic [7:0]       pu;
        logic [TID_W-1:0] pt;
        logic             pl;
        logic             prev_stall;
        logic             exp_rdy;
        prev_stall = 1'b0;
        pd = '0; pu = '0; pt = '0; pl = 1'b0;
        m0.tready = 1'b0;
        fork
            drive_beat(rand_beat(), 1'b1, 1'b1, 1'b1, 7'd0, 3'd4);
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (prev_stall) begin
                    checks++;
                    if ({m0.tvalid, m0.tdata, m0.tuser, m0.tid, m0.tlast} !== {1'b1, pd, pu, pt, pl}) begin
                        fails++;
                        $display("[TB] FAIL stall_hold: got tuser=%h tdata=%h, required tuser=%h tdata=%h",
                                 m0.tuser, m0.tdata, pu, pd);
                    end
                end
                exp_rdy = !m0.tvalid || (m0.tready && m0.tlast);
                checks++;
                if (s0.tready !== exp_rdy) begin
                    fails++;
                    $display("[TB] FAIL stall_s_tready: got %b, required %b", s0.tready, exp_rdy);
                end
                prev_stall = m0.tvalid && !m0.tready;
                pd = m0.tdata; pu = m0.tuser; pt = m0.tid; pl = m0.tlast;
                @(posedge clk);
                #1 m0.tready = 1'($urandom_range(0, 1));
            end
        join
        m0.tready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid_beat();
        m0.tready = 1'b1;
        hs_count  = 0;
        drive_beat(rand_beat(), 1'b1, 1'b1, 1'b1, 7'd0, 3'd7);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (hs_count != 3 || m0.tvalid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_beat_position: got %0d flits sent valid=%b, required 3 and 1", hs_count, m0.tvalid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m0.tvalid, m0.tdata, m0.tuser, m0.tid, m0.tlast, s0.tready} !== '0) begin
            fails++;
            $display("[TB] FAIL async_reset_outputs: got valid=%b user=%h s_tready=%b, required all zero",
                     m0.tvalid, m0.tuser, s0.tready);
        end
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m0.tvalid !== 1'b0 || hs_count != 3) begin
            fails++;
            $display("[TB] FAIL no_replay: got valid=%b flits=%0d, required 0 and 3", m0.tvalid, hs_count);
        end
        drive_beat(rand_beat(), 1'b1, 1'b1, 1'b1, 7'd127, 3'd6);
        wait_drain();
        checks++;
        if (hs_count != 4) begin
            fails++;
            $display("[TB] FAIL post_reset_beat: got %0d flits total, required 4", hs_count);
        end
    endtask

`ifdef AXIS_DN_ERR_CHK_EN
    task automatic test_err_check();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (err0 !== 3'b000) begin
            fails++;
            $display("[TB] FAIL err_after_reset: got %b, required 000", err0);
        end
        m0.tready = 1'b1;
        drive_beat(rand_beat(), 1'b0, 1'b0, 1'b1, 7'd0, 3'd1);
        wait_drain();
        checks++;
        if (err0 !== 3'b001) begin
            fails++;
            $display("[TB] FAIL err_tlast_mismatch: got %b, required 001", err0);
        end
        drive_beat(rand_beat(), 1'b1, 1'b0, 1'b0, 7'd0, 3'd2);
        drive_beat(rand_beat(), 1'b1, 1'b0, 1'b0, 7'd0, 3'd2);
        wait_drain();
        checks++;
        if (err0 !== 3'b011) begin
            fails++;
            $display("[TB] FAIL err_double_sop: got %b, required 011", err0);
        end
        drive_beat(rand_beat(), 1'b0, 1'b0, 1'b0, 7'd9, 3'd2);
        wait_drain();
        checks++;
        if (err0 !== 3'b111 || err1 !== 3'b111) begin
            fails++;
            $display("[TB] FAIL err_empty_non_eop: got %b/%b, required 111", err0, err1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_beat();
        test_two_flit();
        test_non_eop();
        test_back_to_back();
        test_stall();
        test_reset_mid_beat();
`ifdef AXIS_DN_ERR_CHK_EN
        test_err_check();
`endif
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
